// File: rtl/glb_port_arbiter.sv
// glb_port_arbiter: shares the GLB single-read / single-write SRAM ports between
// the host load path and the pass controller's ifmap/filter/ipsum read streams and
// opsum write stream. Round-robin per port, host_lock override, and a one-entry
// response stage that tags each returned read word to the requester that issued it.
// Optional stall statistics are enabled by defining GLB_ARB_STATS_EN.
module glb_port_arbiter #(
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_lock,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_gnt,
    output logic [NUM_RD-1:0]        rd_rvalid,
    output logic [DATA_W-1:0]        rd_rdata,
    input  logic [NUM_WR-1:0]        wr_req,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR*4-1:0]      wr_be,
    output logic [NUM_WR-1:0]        wr_gnt,
    output logic [3:0]               glb_re,
    output logic [ADDR_W-1:0]        glb_r_addr,
    input  logic [DATA_W-1:0]        glb_r_data,
    output logic [3:0]               glb_we,
    output logic [ADDR_W-1:0]        glb_w_addr,
    output logic [DATA_W-1:0]        glb_w_data,
    output logic [15:0]              rd_stall_cnt,
    output logic [15:0]              wr_stall_cnt
);

    localparam int RD_PW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int WR_PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [RD_PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WR_PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [NUM_RD-1:0] rd_elig;
    logic [NUM_WR-1:0] wr_elig;
    logic              rd_found, wr_found;
    logic [RD_PW-1:0]  rd_win, rd_idx;
    logic [WR_PW-1:0]  wr_win, wr_idx;
    logic [ADDR_W-1:0] rd_sel_addr, wr_sel_addr;
    logic [DATA_W-1:0] wr_sel_data;
    logic [3:0]        wr_sel_be;
    logic              rd_conflict;
    logic              rd_grant;
    logic              rsp_valid_q;
    logic [RD_PW-1:0]  rsp_idx_q;

    // host_lock narrows both ports down to requester 0 (the host)
    always_comb begin
        rd_elig = host_lock ? (rd_req & NUM_RD'(1)) : rd_req;
        wr_elig = host_lock ? (wr_req & NUM_WR'(1)) : wr_req;
    end

    // Read round-robin: scan from the far end so the first eligible index at/after the pointer wins
    always_comb begin
        rd_found = 1'b0;
        rd_win   = '0;
        rd_idx   = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            rd_idx = RD_PW'((int'(rd_ptr_q) + i) % NUM_RD);
            if (rd_elig[rd_idx]) begin
                rd_found = 1'b1;
                rd_win   = rd_idx;
            end
        end
    end

    // Write round-robin, same scheme as the read port
    always_comb begin
        wr_found = 1'b0;
        wr_win   = '0;
        wr_idx   = '0;
        for (int i = NUM_WR - 1; i >= 0; i--) begin
            wr_idx = WR_PW'((int'(wr_ptr_q) + i) % NUM_WR);
            if (wr_elig[wr_idx]) begin
                wr_found = 1'b1;
                wr_win   = wr_idx;
            end
        end
    end

    // Winner payloads; a read that hits the word being written this cycle is held back one cycle
    always_comb begin
        rd_sel_addr = rd_addr[int'(rd_win)*ADDR_W +: ADDR_W];
        wr_sel_addr = wr_addr[int'(wr_win)*ADDR_W +: ADDR_W];
        wr_sel_data = wr_data[int'(wr_win)*DATA_W +: DATA_W];
        wr_sel_be   = wr_be[int'(wr_win)*4 +: 4];
        rd_conflict = rd_found && wr_found &&
                      (rd_sel_addr[ADDR_W-1:2] == wr_sel_addr[ADDR_W-1:2]);
        rd_grant    = rd_found && !rd_conflict;
    end

    // Grant and GLB-side outputs; unused address/data lines are parked at 0
    always_comb begin
        rd_gnt     = rd_grant ? (NUM_RD'(1) << rd_win) : '0;
        glb_re     = rd_grant ? 4'hF : 4'h0;
        glb_r_addr = rd_grant ? rd_sel_addr : '0;
        wr_gnt     = wr_found ? (NUM_WR'(1) << wr_win) : '0;
        glb_we     = wr_found ? wr_sel_be : 4'h0;
        glb_w_addr = wr_found ? wr_sel_addr : '0;
        glb_w_data = wr_found ? wr_sel_data : '0;
    end

    // Pointers advance past the winner on a grant and hold otherwise
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (rd_grant) begin
            rd_ptr_d = (rd_win == RD_PW'(NUM_RD - 1)) ? '0 : rd_win + 1'b1;
        end
        if (wr_found) begin
            wr_ptr_d = (wr_win == WR_PW'(NUM_WR - 1)) ? '0 : wr_win + 1'b1;
        end
    end

    // Pointer registers and the one-deep read response stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rsp_valid_q <= rd_grant;
            rsp_idx_q   <= rd_win;
        end
    end

    // Returned word goes to everyone; rd_rvalid tells the issuing requester it is theirs
    always_comb begin
        rd_rvalid = rsp_valid_q ? (NUM_RD'(1) << rsp_idx_q) : '0;
        rd_rdata  = glb_r_data;
    end

`ifdef GLB_ARB_STATS_EN
    logic [15:0] rd_stall_q, wr_stall_q;
    logic        wr_loser;

    assign wr_loser = |(wr_elig & ~wr_gnt);

    // Saturating stall counters: read conflicts and cycles with an eligible write left waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_stall_q <= '0;
            wr_stall_q <= '0;
        end else begin
            if (rd_conflict && (rd_stall_q != 16'hFFFF)) begin
                rd_stall_q <= rd_stall_q + 16'd1;
            end
            if (wr_loser && (wr_stall_q != 16'hFFFF)) begin
                wr_stall_q <= wr_stall_q + 16'd1;
            end
        end
    end

    assign rd_stall_cnt = rd_stall_q;
    assign wr_stall_cnt = wr_stall_q;
`else
    assign rd_stall_cnt = 16'h0000;
    assign wr_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_glb_port_arbiter.sv
// tb_glb_port_arbiter: table-driven directed test of glb_port_arbiter with a small
// GLB SRAM model behind it, plus hand-written reset and write round-robin sequences.
module tb_glb_port_arbiter;

`ifdef GLB_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic         clk;
    logic         rst_n;
    logic         host_lock;
    logic [3:0]   rd_req;
    logic [127:0] rd_addr;
    logic [3:0]   rd_gnt;
    logic [3:0]   rd_rvalid;
    logic [31:0]  rd_rdata;
    logic [1:0]   wr_req;
    logic [63:0]  wr_addr;
    logic [63:0]  wr_data;
    logic [7:0]   wr_be;
    logic [1:0]   wr_gnt;
    logic [3:0]   glb_re;
    logic [31:0]  glb_r_addr;
    logic [31:0]  glb_r_data;
    logic [3:0]   glb_we;
    logic [31:0]  glb_w_addr;
    logic [31:0]  glb_w_data;
    logic [15:0]  rd_stall_cnt;
    logic [15:0]  wr_stall_cnt;

    int total;
    int bad;

    logic [31:0] mem [64];

    typedef struct {
        logic        lock;
        logic [3:0]  rr;
        logic [31:0] a1;
        logic [1:0]  wr;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [3:0]  be0;
        logic [3:0]  e_rgnt;
        logic [31:0] e_raddr;
        logic [1:0]  e_wgnt;
        logic [3:0]  e_we;
        logic [31:0] e_waddr;
        logic [3:0]  e_rv;
        logic [31:0] e_rdata;
        int          e_rs;
    } vec_t;

    vec_t vecs [19];

    glb_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_lock    (host_lock),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_rvalid    (rd_rvalid),
        .rd_rdata     (rd_rdata),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_be        (wr_be),
        .wr_gnt       (wr_gnt),
        .glb_re       (glb_re),
        .glb_r_addr   (glb_r_addr),
        .glb_r_data   (glb_r_data),
        .glb_we       (glb_we),
        .glb_w_addr   (glb_w_addr),
        .glb_w_data   (glb_w_data),
        .rd_stall_cnt (rd_stall_cnt),
        .wr_stall_cnt (wr_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GLB SRAM stand-in: one-cycle read latency, byte-masked writes
    always @(posedge clk) begin
        if (glb_re == 4'hF) begin
            glb_r_data <= mem[glb_r_addr[7:2]];
        end
        for (int b = 0; b < 4; b++) begin
            if (glb_we[b]) begin
                mem[glb_w_addr[7:2]][b*8 +: 8] <= glb_w_data[b*8 +: 8];
            end
        end
    end

    // Fixed addresses: host rd 0x00, filter 0x20, ipsum 0x30, opsum wr 0x84 / 0x55555555
    task automatic applyStimulus(input logic lock, input logic [3:0] rr, input logic [31:0] a1,
                                 input logic [1:0] wr, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic [3:0] be0);
        host_lock = lock;
        rd_req    = rr;
        rd_addr   = {32'h30, 32'h20, a1, 32'h00};
        wr_req    = wr;
        wr_addr   = {32'h84, a0};
        wr_data   = {32'h5555_5555, d0};
        wr_be     = {4'hF, be0};
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] e_wdata;
        total = 0;
        bad   = 0;
        glb_r_data = '0;
        for (int w = 0; w < 64; w++) mem[w] = 32'hC0DE_0000 | w;
        mem[20] = 32'hAAAA_AAAA;

        //            lock rr       a1     wr     a0     d0            be0    rgnt     raddr  wgnt   we     waddr  rv       rdata          rs
        vecs[0]  = '{1'b0, 4'b1110, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0010, 32'h10, 2'b00, 4'h0,  32'h0,  4'b0000, 32'h0,         0};
        vecs[1]  = '{1'b0, 4'b1110, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0100, 32'h20, 2'b00, 4'h0,  32'h0,  4'b0010, 32'hC0DE0004,  0};
        vecs[2]  = '{1'b0, 4'b1110, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b1000, 32'h30, 2'b00, 4'h0,  32'h0,  4'b0100, 32'hC0DE0008,  0};
        vecs[3]  = '{1'b0, 4'b1110, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0010, 32'h10, 2'b00, 4'h0,  32'h0,  4'b1000, 32'hC0DE000C,  0};
        vecs[4]  = '{1'b0, 4'b1110, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0100, 32'h20, 2'b00, 4'h0,  32'h0,  4'b0010, 32'hC0DE0004,  0};
        vecs[5]  = '{1'b0, 4'b1110, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b1000, 32'h30, 2'b00, 4'h0,  32'h0,  4'b0100, 32'hC0DE0008,  0};
        vecs[6]  = '{1'b0, 4'b0000, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0000, 32'h0,  2'b00, 4'h0,  32'h0,  4'b1000, 32'hC0DE000C,  0};
        vecs[7]  = '{1'b1, 4'b1111, 32'h10, 2'b11, 32'h80, 32'h11111111, 4'hF,  4'b0001, 32'h0,  2'b01, 4'hF,  32'h80, 4'b0000, 32'h0,         0};
        vecs[8]  = '{1'b0, 4'b1111, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0010, 32'h10, 2'b00, 4'h0,  32'h0,  4'b0001, 32'hC0DE0000,  0};
        vecs[9]  = '{1'b0, 4'b0000, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0000, 32'h0,  2'b00, 4'h0,  32'h0,  4'b0010, 32'hC0DE0004,  0};
        vecs[10] = '{1'b0, 4'b0010, 32'h40, 2'b01, 32'h40, 32'hDEADBEEF, 4'hF,  4'b0000, 32'h0,  2'b01, 4'hF,  32'h40, 4'b0000, 32'h0,         0};
        vecs[11] = '{1'b0, 4'b0010, 32'h40, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0010, 32'h40, 2'b00, 4'h0,  32'h0,  4'b0000, 32'h0,         1};
        vecs[12] = '{1'b0, 4'b0000, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0000, 32'h0,  2'b00, 4'h0,  32'h0,  4'b0010, 32'hDEADBEEF,  1};
        vecs[13] = '{1'b0, 4'b0000, 32'h10, 2'b01, 32'h50, 32'h11223344, 4'h3,  4'b0000, 32'h0,  2'b01, 4'h3,  32'h50, 4'b0000, 32'h0,         1};
        vecs[14] = '{1'b0, 4'b0010, 32'h50, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0010, 32'h50, 2'b00, 4'h0,  32'h0,  4'b0000, 32'h0,         1};
        vecs[15] = '{1'b0, 4'b0000, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0000, 32'h0,  2'b00, 4'h0,  32'h0,  4'b0010, 32'hAAAA3344,  1};
        vecs[16] = '{1'b0, 4'b0000, 32'h10, 2'b01, 32'h50, 32'hFFFFFFFF, 4'h0,  4'b0000, 32'h0,  2'b01, 4'h0,  32'h50, 4'b0000, 32'h0,         1};
        vecs[17] = '{1'b0, 4'b0010, 32'h50, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0010, 32'h50, 2'b00, 4'h0,  32'h0,  4'b0000, 32'h0,         1};
        vecs[18] = '{1'b0, 4'b0000, 32'h10, 2'b00, 32'h0,  32'h0,        4'h0,  4'b0000, 32'h0,  2'b00, 4'h0,  32'h0,  4'b0010, 32'hAAAA3344,  1};

        rst_n = 1'b0;
        applyStimulus(1'b0, 4'b0000, 32'h10, 2'b00, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset rd_gnt",       32'(rd_gnt),       32'h0);
        checkOutput("reset wr_gnt",       32'(wr_gnt),       32'h0);
        checkOutput("reset rd_rvalid",    32'(rd_rvalid),    32'h0);
        checkOutput("reset glb_re",       32'(glb_re),       32'h0);
        checkOutput("reset glb_we",       32'(glb_we),       32'h0);
        checkOutput("reset glb_r_addr",   glb_r_addr,        32'h0);
        checkOutput("reset glb_w_addr",   glb_w_addr,        32'h0);
        checkOutput("reset glb_w_data",   glb_w_data,        32'h0);
        checkOutput("reset rd_stall_cnt", 32'(rd_stall_cnt), 32'h0);
        checkOutput("reset wr_stall_cnt", 32'(wr_stall_cnt), 32'h0);
        rst_n = 1'b1;

        for (int r = 0; r < 19; r++) begin
            @(negedge clk);
            applyStimulus(vecs[r].lock, vecs[r].rr, vecs[r].a1, vecs[r].wr,
                          vecs[r].a0, vecs[r].d0, vecs[r].be0);
            #1;
            e_wdata = (vecs[r].e_wgnt == 2'b01) ? vecs[r].d0 :
                      (vecs[r].e_wgnt == 2'b10) ? 32'h5555_5555 : 32'h0;
            checkOutput($sformatf("row%0d rd_gnt", r),     32'(rd_gnt),     32'(vecs[r].e_rgnt));
            checkOutput($sformatf("row%0d glb_re", r),     32'(glb_re),     (vecs[r].e_rgnt != 4'b0) ? 32'hF : 32'h0);
            checkOutput($sformatf("row%0d glb_r_addr", r), glb_r_addr,      vecs[r].e_raddr);
            checkOutput($sformatf("row%0d wr_gnt", r),     32'(wr_gnt),     32'(vecs[r].e_wgnt));
            checkOutput($sformatf("row%0d glb_we", r),     32'(glb_we),     32'(vecs[r].e_we));
            checkOutput($sformatf("row%0d glb_w_addr", r), glb_w_addr,      vecs[r].e_waddr);
            checkOutput($sformatf("row%0d glb_w_data", r), glb_w_data,      e_wdata);
            checkOutput($sformatf("row%0d rd_rvalid", r),  32'(rd_rvalid),  32'(vecs[r].e_rv));
            if (vecs[r].e_rv != 4'b0) begin
                checkOutput($sformatf("row%0d rd_rdata", r), rd_rdata, vecs[r].e_rdata);
            end
            checkOutput($sformatf("row%0d rd_stall_cnt", r), 32'(rd_stall_cnt), 32'(vecs[r].e_rs * STATS));
            checkOutput($sformatf("row%0d wr_stall_cnt", r), 32'(wr_stall_cnt), 32'h0);
        end

        // Reset landing right after a granted read: response must vanish, pointers restart
        @(negedge clk);
        applyStimulus(1'b0, 4'b0100, 32'h10, 2'b00, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("pre-reset rd_gnt", 32'(rd_gnt), 32'b0100);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'b0000, 32'h10, 2'b00, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("mid-reset rd_rvalid", 32'(rd_rvalid), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("held-reset rd_rvalid",    32'(rd_rvalid),    32'h0);
        checkOutput("held-reset rd_gnt",       32'(rd_gnt),       32'h0);
        checkOutput("held-reset glb_re",       32'(glb_re),       32'h0);
        checkOutput("held-reset glb_r_addr",   glb_r_addr,        32'h0);
        checkOutput("held-reset rd_stall_cnt", 32'(rd_stall_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'b1111, 32'h10, 2'b00, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("post-reset rd ptr grant", 32'(rd_gnt),    32'b0001);
        checkOutput("post-reset rd_rvalid",    32'(rd_rvalid), 32'h0);

        // Two writers held for four cycles: strict alternation starting at host
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 4'b0000, 32'h10, 2'b11, 32'h80, 32'h11111111, 4'hF);
            #1;
            checkOutput($sformatf("wr rr %0d wr_gnt", k), 32'(wr_gnt),
                        (k % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput($sformatf("wr rr %0d glb_w_addr", k), glb_w_addr,
                        (k % 2 == 0) ? 32'h80 : 32'h84);
        end
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 32'h10, 2'b00, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("final wr_stall_cnt", 32'(wr_stall_cnt), 32'(4 * STATS));
        checkOutput("final rd_stall_cnt", 32'(rd_stall_cnt), 32'h0);
        checkOutput("final wr_gnt",       32'(wr_gnt),       32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glb_port_arbiter.md
# glb_port_arbiter

Shares the single-read / single-write GLB SRAM ports between the host DRAM-load path and the pass controller's ifmap, filter, ipsum read streams and opsum write stream. It performs round-robin arbitration per port, with a host-lock override for the load/drain phases. It tracks the one-cycle GLB read latency so that each returned word is tagged to the requester that issued it. The block sits between the host/controller request sources and the GLB instance in the top level, and replaces the static op_config-based mux.

## Interface
- NUM_RD, 4: read requesters; index 0 = host, 1 = ifmap, 2 = filter, 3 = ipsum.
- NUM_WR, 2: write requesters; index 0 = host, 1 = opsum.
- ADDR_W, 32: byte address width.
- DATA_W, 32: GLB word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- host_lock  in  1  when 1, only requester 0 of each port may be granted.
- rd_req  in  NUM_RD  read request per requester; held until granted.
- rd_addr  in  NUM_RD*ADDR_W  packed read byte addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- rd_gnt  out  NUM_RD  one-hot read grant, same cycle as the request.
- rd_rvalid  out  NUM_RD  one-hot, asserted the cycle after a read grant.
- rd_rdata  out  DATA_W  read data, broadcast to all requesters; qualified by rd_rvalid.
- wr_req  in  NUM_WR  write request per requester.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- wr_be  in  NUM_WR*4  packed byte enables.
- wr_gnt  out  NUM_WR  one-hot write grant; the write completes in the grant cycle.
- glb_re  out  4  GLB read enable; 4'hF when a read is granted, else 0.
- glb_r_addr  out  ADDR_W  address of the granted read.
- glb_r_data  in  DATA_W  GLB read data; valid one cycle after glb_re.
- glb_we  out  4  byte enables of the granted write, else 0.
- glb_w_addr  out  ADDR_W  address of the granted write.
- glb_w_data  out  DATA_W  data of the granted write.
- rd_stall_cnt  out  16  saturating count of read-conflict stalls (see Configuration).
- wr_stall_cnt  out  16  saturating count of write-loser cycles (see Configuration).

## Operation
- Read and write ports arbitrate independently in the same cycle.
- **Eligible set:** all requesters with req=1, masked to index 0 when host_lock=1.
- **Round-robin:**
  - Each port has a pointer, reset to 0.
  - The winner is the first eligible index at or after the pointer, wrapping modulo NUM.
  - On a grant, the pointer becomes (winner+1) mod NUM. With no grant, the pointer holds.
- **Read grant:** drive glb_re=4'hF and glb_r_addr=rd_addr[winner]. Register winner and valid into the response stage.
- **Response stage:** the cycle after a grant, rd_rvalid[winner_q]=1 and rd_rdata=glb_r_data. rd_rdata is passed combinationally from glb_r_data and is not re-registered.
- **Write grant:** drive glb_we=wr_be[winner], glb_w_addr and glb_w_data from the winner. wr_be=0 is a legal no-op that is still granted.
- **Read/write same-word conflict:** both ports winning with equal addr[ADDR_W-1:2] in one cycle.
  - The read is withheld: rd_gnt=0, glb_re=0, read pointer holds.
  - The write proceeds.
  - The read wins next cycle if still eligible. It returns the new data, so there is no stale read.
- **host_lock change:** takes effect on the same-cycle grant. An in-flight response still completes.
- **Unused outputs:** glb_*_addr and glb_w_data drive 0 when not granted.

## Timing
- Reset values: rd_gnt, wr_gnt, rd_rvalid, glb_re, glb_we, glb_r_addr, glb_w_addr, glb_w_data, both stall counters = 0; both pointers = 0; response stage empty.
- Grant is combinational from req/pointer/host_lock. Arbitration latency is 0 cycles.
- Read data latency: exactly 1 cycle after rd_gnt. Reads are back-to-back at full throughput, one per cycle.
- A requester sees rd_gnt, then drops or changes req/addr on the next edge. Holding req after a grant issues a second read.
- Reset asserted mid-operation clears the response stage. A read granted in the cycle before reset yields no rd_rvalid.
- Max wait for an eligible requester under continuous contention: NUM-1 grants, plus 1 cycle per read/write conflict.

## Configuration
- `GLB_ARB_STATS_EN` defined:
  - rd_stall_cnt increments each cycle a read is withheld by a conflict.
  - wr_stall_cnt increments each cycle at least one write requester is eligible but not granted.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear on reset.
- `GLB_ARB_STATS_EN` undefined: both outputs are tied to 0 and no counter flops are synthesized. Arbitration behaviour is identical either way.

## Test plan
- Reads only, rd_req=4'b1110 held 6 cycles, pointer 0 → grants in order 1,2,3,1,2,3. Each rd_rvalid is one cycle after its grant, with data matching preloaded GLB words.
- host_lock=1, rd_req=4'b1111, wr_req=2'b11 → only rd_gnt[0] and wr_gnt[0] are granted. Deassert lock → the next read grant goes to index 1.
- Same cycle: write word 0x40=0xDEADBEEF (be=4'hF) and read 0x40 → the write is granted and the read is withheld. The read is granted next cycle, returns 0xDEADBEEF, and rd_stall_cnt=1 with the macro defined (0 without).
- Write be=4'b0011 of 0x11223344 onto 0xAAAAAAAA → a subsequent read returns 0xAAAA3344.
- Read granted, then rst_n pulsed low the next cycle → rd_rvalid stays 0, all outputs read 0, and the pointers restart at 0.
- wr_req=2'b11 held 4 cycles → wr_gnt alternates 0,1,0,1. wr_stall_cnt=4 with the macro defined.
